cache_dm_wt: RTL

//  Parametrised direct-mapped, write-through, no-write-allocate cache between a single requester and word-addressed RAM.

---
 rtl/cache_dm_wt_pkg.sv | 15 +
 rtl/cache_dm_wt_store.sv | 46 ++++
 rtl/cache_dm_wt.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cache_dm_wt_pkg.sv
// Shared types and helpers for the direct-mapped write-through cache.
// Optional statistics counters are enabled with CACHE_DM_WT_STATS_EN.
package cache_dm_wt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    function automatic int tag_width(input int mem_addr_w, input int index_w);
        return mem_addr_w - index_w;
    endfunction

endpackage

// File: rtl/cache_dm_wt_store.sv
// Line storage: valid bits, tags and data words for a direct-mapped cache.
// Asynchronous read by index, synchronous single write port.
module cache_dm_wt_store #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    localparam int DEPTH = 2 ** INDEX_W;

    logic [DEPTH-1:0]  valid;
    logic [TAG_W-1:0]  tags [DEPTH];
    logic [DATA_W-1:0] data [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data arrays need no reset: the valid bit gates them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];

endmodule

// File: rtl/cache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate cache in front of word RAM.
// Define CACHE_DM_WT_STATS_EN to add saturating read hit/miss counters.
module cache_dm_wt
    import cache_dm_wt_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 12,
    parameter int INDEX_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack
`ifdef CACHE_DM_WT_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int TAG_W = tag_width(MEM_ADDR_W, INDEX_W);

    state_t state;

    logic [MEM_ADDR_W-1:0] a;
    logic [MEM_ADDR_W-1:0] lk_addr;
    logic [INDEX_W-1:0]    lk_index;
    logic [TAG_W-1:0]      lk_tag;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [DATA_W-1:0]     line_data;
    logic                  hit;
    logic                  accept;
    logic                  wr_en;
    logic [DATA_W-1:0]     wr_data;
    logic                  unused_addr_bits;

    assign a                = req_addr[MEM_ADDR_W-1:0];
    assign unused_addr_bits = ^req_addr[ADDR_W-1:MEM_ADDR_W];

    // Look up the incoming request while idle, the held request otherwise.
    assign lk_addr  = (state == IDLE) ? a : mem_addr;
    assign lk_index = lk_addr[INDEX_W-1:0];
    assign lk_tag   = lk_addr[MEM_ADDR_W-1:INDEX_W];
    assign hit      = line_valid && (line_tag == lk_tag);
    assign accept   = req_valid && req_ready && (state == IDLE);

    assign wr_en = mem_ack &&
                   ((state == RD_MISS) || ((state == WR_THRU) && hit));
    assign wr_data = (state == RD_MISS) ? mem_rdata : mem_wdata;

    cache_dm_wt_store #(
        .INDEX_W(INDEX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .rd_index(lk_index),
        .rd_valid(line_valid),
        .rd_tag  (line_tag),
        .rd_data (line_data),
        .wr_en   (wr_en),
        .wr_index(mem_addr[INDEX_W-1:0]),
        .wr_tag  (mem_addr[MEM_ADDR_W-1:INDEX_W]),
        .wr_data (wr_data)
    );

    // mem_addr/mem_wdata/mem_write double as the held request fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            mem_req    <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_write) begin
                            state     <= WR_THRU;
                            req_ready <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_write <= 1'b1;
                            mem_addr  <= a;
                            mem_wdata <= req_wdata;
                        end else if (hit) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= line_data;
                        end else begin
                            state     <= RD_MISS;
                            req_ready <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_write <= 1'b0;
                            mem_addr  <= a;
                        end
                    end
                end
                RD_MISS: begin
                    if (mem_ack) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= mem_rdata;
                    end
                end
                WR_THRU: begin
                    if (mem_ack) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef CACHE_DM_WT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept && !req_write) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
